// File: rtl/ienc_pkg.sv
`default_nettype none
// ============================================================================
// Package     : ienc_pkg
// Description : Shared widths, FIFO entry layout, opcode tables and FSM
//               state encodings for the instruction fetch encoder.
// Revision    : 1.0 - initial release
// ============================================================================
package ienc_pkg;

    localparam int c_opw   = 7;
    localparam int c_oprw  = 25;
    localparam int c_immw  = 32;
    localparam int c_wordw = 32;

    // One buffered instruction: opcode, operand fields, optional immediate.
    typedef struct packed {
        logic [c_opw-1:0]  opecode;
        logic [c_oprw-1:0] oprnd;
        logic [c_immw-1:0] limm;
        logic              limmv;
    } entry_t;

    localparam int c_entw = $bits(entry_t);

    typedef enum logic [1:0] {
        CLS_NORMAL = 2'd0,
        CLS_LIMM   = 2'd1,
        CLS_RSVD   = 2'd2
    } op_class_t;

    // Opcodes that are followed by a 32-bit immediate word.
    localparam logic [c_opw-1:0] c_limm_op0 = 7'd96;
    localparam logic [c_opw-1:0] c_limm_op1 = 7'd97;
    localparam logic [c_opw-1:0] c_limm_op2 = 7'd98;
    localparam logic [c_opw-1:0] c_limm_op3 = 7'd100;
    localparam logic [c_opw-1:0] c_limm_op4 = 7'd101;
    localparam logic [c_opw-1:0] c_limm_op5 = 7'd102;

    // Bit n set means opcode n is reserved.
    localparam logic [127:0] c_rsvd_map = 128'hFF54_B488_3820_0C68_FC42_10C0_18E0_C008;

    // Fetch FSM: expecting an opcode word, or the immediate of a staged LIMM.
    localparam logic [0:0] S_OP  = 1'b0;
    localparam logic [0:0] S_IMM = 1'b1;

endpackage : ienc_pkg
`default_nettype wire

// File: rtl/inst_fetch_encoder_if.sv
`default_nettype none
// ============================================================================
// Interface   : inst_fetch_encoder_if
// Description : Host word input, decode-stage instruction output and error
//               status of the instruction fetch encoder.
// Revision    : 1.0 - initial release
// ============================================================================
interface inst_fetch_encoder_if
    import ienc_pkg::*;
#(
    parameter int ERRW = 8
);
    logic                wvld_i_ienc;
    logic [c_wordw-1:0]  wdat_i_ienc;
    logic                wrdy_o_ienc;
    logic                ivld_o_ienc;
    logic                irdy_i_ienc;
    logic [c_opw-1:0]    opecode_o_ienc;
    logic [c_oprw-1:0]   oprnd_o_ienc;
    logic [c_immw-1:0]   limm_o_ienc;
    logic                limmv_o_ienc;
    logic                err_o_ienc;
    logic [ERRW-1:0]     errcnt_o_ienc;
    logic                clrerr_i_ienc;

    modport master (
        input  wvld_i_ienc, wdat_i_ienc, irdy_i_ienc, clrerr_i_ienc,
        output wrdy_o_ienc, ivld_o_ienc, opecode_o_ienc, oprnd_o_ienc,
               limm_o_ienc, limmv_o_ienc, err_o_ienc, errcnt_o_ienc
    );

    modport slave (
        output wvld_i_ienc, wdat_i_ienc, irdy_i_ienc, clrerr_i_ienc,
        input  wrdy_o_ienc, ivld_o_ienc, opecode_o_ienc, oprnd_o_ienc,
               limm_o_ienc, limmv_o_ienc, err_o_ienc, errcnt_o_ienc
    );

endinterface : inst_fetch_encoder_if
`default_nettype wire

// File: rtl/ienc_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ienc_fifo
// Description : Synchronous FIFO with registered head, occupancy counter and
//               full/empty flags. DEPTH must be a power of two, at least 2.
// Revision    : 1.0 - initial release
// ============================================================================
module ienc_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 65
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             push,
    input  wire logic [WIDTH-1:0] push_data,
    input  wire logic             pop,
    output logic      [WIDTH-1:0] head,
    output logic                  full,
    output logic                  empty
);
    localparam int              c_aw   = $clog2(DEPTH);
    localparam logic [c_aw:0]   c_full = DEPTH[c_aw:0];

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_aw:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_count == c_full);
    assign empty     = (r_count == '0);
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;
    assign head      = r_mem[r_rd_ptr];

    // Storage, wrapping pointers and occupancy; push+pop leaves count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : ienc_fifo
`default_nettype wire

// File: rtl/inst_fetch_encoder.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch_encoder
// Description : Classifies host instruction words, pairs long-immediate
//               opcodes with their immediate, drops and counts reserved
//               opcodes, and buffers instructions for the decode stage.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch_encoder
    import ienc_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int ERRW  = 8
) (
    input  wire logic          clk,
    input  wire logic          rst,
    inst_fetch_encoder_if.master bus
);
    logic [0:0]        r_state;
    logic [0:0]        w_next_state;
    logic [c_opw-1:0]  r_stage_op;
    logic [c_oprw-1:0] r_stage_oprnd;
    logic              r_err;
    logic [ERRW-1:0]   r_errcnt;

    logic              w_xfer;
    logic              w_push;
    logic              w_stage_ld;
    logic              w_rsvd_hit;
    logic              w_full;
    logic              w_empty;
    entry_t            w_push_entry;
    entry_t            w_head;
    op_class_t         w_class;
    logic [c_opw-1:0]  w_op;
    logic [c_oprw-1:0] w_oprnd;

    function automatic op_class_t classify(input logic [c_opw-1:0] op);
        if (c_rsvd_map[op]) begin
            return CLS_RSVD;
        end
        case (op)
            c_limm_op0, c_limm_op1, c_limm_op2,
            c_limm_op3, c_limm_op4, c_limm_op5: return CLS_LIMM;
            default:                            return CLS_NORMAL;
        endcase
    endfunction

    assign w_op    = bus.wdat_i_ienc[31:25];
    assign w_oprnd = bus.wdat_i_ienc[24:0];
    assign w_class = classify(w_op);

    // Ready depends only on registered occupancy, never on irdy.
    assign bus.wrdy_o_ienc = !w_full && !rst;
    assign w_xfer          = bus.wvld_i_ienc && bus.wrdy_o_ienc;

    // State register; reset drops any half-assembled LIMM instruction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_OP;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state: enter S_IMM on an accepted LIMM opcode, leave on its immediate.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_OP:    if (w_xfer && (w_class == CLS_LIMM)) w_next_state = S_IMM;
            S_IMM:   if (w_xfer) w_next_state = S_OP;
            default: w_next_state = S_OP;
        endcase
    end

    // Per-state actions on a host transfer; the immediate word is never classified.
    always_comb begin
        w_push       = 1'b0;
        w_stage_ld   = 1'b0;
        w_rsvd_hit   = 1'b0;
        w_push_entry = '0;
        if (w_xfer) begin
            case (r_state)
                S_OP: begin
                    case (w_class)
                        CLS_NORMAL: begin
                            w_push               = 1'b1;
                            w_push_entry.opecode = w_op;
                            w_push_entry.oprnd   = w_oprnd;
                        end
                        CLS_LIMM: w_stage_ld = 1'b1;
                        default:  w_rsvd_hit = 1'b1;
                    endcase
                end
                S_IMM: begin
                    w_push               = 1'b1;
                    w_push_entry.opecode = r_stage_op;
                    w_push_entry.oprnd   = r_stage_oprnd;
                    w_push_entry.limm    = bus.wdat_i_ienc;
                    w_push_entry.limmv   = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Staging register holds a LIMM opcode until its immediate arrives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stage_op    <= '0;
            r_stage_oprnd <= '0;
        end else if (w_stage_ld) begin
            r_stage_op    <= w_op;
            r_stage_oprnd <= w_oprnd;
        end
    end

    // Sticky error flag and saturating counter; clear wins over a same-cycle hit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err    <= 1'b0;
            r_errcnt <= '0;
        end else if (bus.clrerr_i_ienc) begin
            r_err    <= 1'b0;
            r_errcnt <= '0;
        end else if (w_rsvd_hit) begin
            r_err <= 1'b1;
            if (r_errcnt != '1) begin
                r_errcnt <= r_errcnt + 1'b1;
            end
        end
    end

    ienc_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (c_entw)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (w_push_entry),
        .pop       (bus.irdy_i_ienc),
        .head      (w_head),
        .full      (w_full),
        .empty     (w_empty)
    );

    assign bus.ivld_o_ienc    = !w_empty;
    assign bus.opecode_o_ienc = w_head.opecode;
    assign bus.oprnd_o_ienc   = w_head.oprnd;
    assign bus.limm_o_ienc    = w_head.limm;
    assign bus.limmv_o_ienc   = w_head.limmv;
    assign bus.err_o_ienc     = r_err;
    assign bus.errcnt_o_ienc  = r_errcnt;

endmodule : inst_fetch_encoder
`default_nettype wire

// File: tb/tb_inst_fetch_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_fetch_encoder
// Description : Directed self-checking bench for inst_fetch_encoder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_fetch_encoder;

    localparam int DEPTH = 4;
    localparam int ERRW  = 8;

    logic clk = 1'b0;
    logic rst;
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    inst_fetch_encoder_if #(.ERRW(ERRW)) bus ();

    inst_fetch_encoder #(
        .DEPTH (DEPTH),
        .ERRW  (ERRW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic put(input logic [31:0] w);
        bus.wvld_i_ienc = 1'b1;
        bus.wdat_i_ienc = w;
        step();
    endtask

    initial begin
        rst               = 1'b1;
        bus.wvld_i_ienc   = 1'b0;
        bus.wdat_i_ienc   = '0;
        bus.irdy_i_ienc   = 1'b0;
        bus.clrerr_i_ienc = 1'b0;
        step();
        step();

        // Reset state
        check("rst_wrdy",   bus.wrdy_o_ienc,   0);
        check("rst_ivld",   bus.ivld_o_ienc,   0);
        check("rst_err",    bus.err_o_ienc,    0);
        check("rst_errcnt", bus.errcnt_o_ienc, 0);
        check("rst_limm",   bus.limm_o_ienc,   0);
        rst = 1'b0;
        #1;
        check("rel_wrdy", bus.wrdy_o_ienc, 1);
        @(negedge clk);

        // Normal pass-through
        bus.irdy_i_ienc = 1'b1;
        put(32'h0000_0001);
        bus.wvld_i_ienc = 1'b0;
        check("norm_ivld",  bus.ivld_o_ienc,    1);
        check("norm_op",    bus.opecode_o_ienc, 0);
        check("norm_oprnd", bus.oprnd_o_ienc,   1);
        check("norm_limmv", bus.limmv_o_ienc,   0);
        check("norm_limm",  bus.limm_o_ienc,    0);
        step();
        check("norm_drain", bus.ivld_o_ienc, 0);

        // Long immediate
        put(32'hC000_0005);
        check("limm_gap_ivld", bus.ivld_o_ienc, 0);
        put(32'hDEAD_BEEF);
        bus.wvld_i_ienc = 1'b0;
        check("limm_ivld",  bus.ivld_o_ienc,    1);
        check("limm_op",    bus.opecode_o_ienc, 96);
        check("limm_oprnd", bus.oprnd_o_ienc,   5);
        check("limm_data",  bus.limm_o_ienc,    64'hDEAD_BEEF);
        check("limm_v",     bus.limmv_o_ienc,   1);
        step();
        check("limm_drain", bus.ivld_o_ienc, 0);

        // Reserved drop: opcodes 3, 127, then 0
        put(32'h0600_0000);
        put(32'hFE00_0000);
        check("rsvd_no_out", bus.ivld_o_ienc, 0);
        put(32'h0000_0000);
        bus.wvld_i_ienc = 1'b0;
        check("rsvd_ivld",   bus.ivld_o_ienc,    1);
        check("rsvd_op",     bus.opecode_o_ienc, 0);
        check("rsvd_err",    bus.err_o_ienc,     1);
        check("rsvd_errcnt", bus.errcnt_o_ienc,  2);
        step();
        check("rsvd_drain", bus.ivld_o_ienc, 0);
        bus.clrerr_i_ienc = 1'b1;
        step();
        bus.clrerr_i_ienc = 1'b0;
        check("clr_err",    bus.err_o_ienc,    0);
        check("clr_errcnt", bus.errcnt_o_ienc, 0);

        // Clear beats a same-cycle reserved hit; a later hit still counts
        bus.clrerr_i_ienc = 1'b1;
        put(32'h0600_0000);
        bus.clrerr_i_ienc = 1'b0;
        check("clrpri_err",    bus.err_o_ienc,    0);
        check("clrpri_errcnt", bus.errcnt_o_ienc, 0);
        put(32'h0600_0000);
        bus.wvld_i_ienc = 1'b0;
        check("after_clr_errcnt", bus.errcnt_o_ienc, 1);

        // Backpressure: fill DEPTH entries, hold the extra word
        bus.irdy_i_ienc = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            bus.wvld_i_ienc = 1'b1;
            bus.wdat_i_ienc = 32'h10 + 32'(i);
            #1;
            check($sformatf("bp_wrdy_%0d", i), bus.wrdy_o_ienc, 1);
            @(negedge clk);
        end
        bus.wdat_i_ienc = 32'h14;
        check("bp_full_wrdy", bus.wrdy_o_ienc,  0);
        check("bp_head",      bus.oprnd_o_ienc, 32'h10);
        step();
        check("bp_stable_head", bus.oprnd_o_ienc, 32'h10);
        check("bp_stable_vld",  bus.ivld_o_ienc,  1);
        bus.irdy_i_ienc = 1'b1;
        #1;
        check("bp_pop_no_wrdy", bus.wrdy_o_ienc, 0);
        @(negedge clk);
        check("bp_out0",   bus.oprnd_o_ienc, 32'h11);
        check("bp_rewrdy", bus.wrdy_o_ienc,  1);
        step();
        bus.wvld_i_ienc = 1'b0;
        check("bp_out1", bus.oprnd_o_ienc, 32'h12);
        step();
        check("bp_out2", bus.oprnd_o_ienc, 32'h13);
        step();
        check("bp_out3", bus.oprnd_o_ienc, 32'h14);
        check("bp_out3_vld", bus.ivld_o_ienc, 1);
        step();
        check("bp_empty", bus.ivld_o_ienc, 0);

        // Reset in the middle of a LIMM pair
        bus.irdy_i_ienc = 1'b0;
        put(32'h0000_0007);
        put(32'hC200_0000);
        bus.wvld_i_ienc = 1'b0;
        check("mid_pre_ivld", bus.ivld_o_ienc, 1);
        rst = 1'b1;
        #1;
        check("mid_async_ivld",   bus.ivld_o_ienc,    0);
        check("mid_async_oprnd",  bus.oprnd_o_ienc,   0);
        check("mid_async_errcnt", bus.errcnt_o_ienc,  0);
        @(negedge clk);
        step();
        rst = 1'b0;
        bus.irdy_i_ienc = 1'b1;
        put(32'hDEAD_BEEF);
        bus.wvld_i_ienc = 1'b0;
        check("mid_ivld",   bus.ivld_o_ienc,   0);
        check("mid_err",    bus.err_o_ienc,    1);
        check("mid_errcnt", bus.errcnt_o_ienc, 1);

        // Counter saturation
        bus.clrerr_i_ienc = 1'b1;
        step();
        bus.clrerr_i_ienc = 1'b0;
        for (int i = 0; i < 300; i++) begin
            put(32'h0600_0000);
            if (i == 254) check("sat_reach", bus.errcnt_o_ienc, 255);
        end
        bus.wvld_i_ienc = 1'b0;
        check("sat_hold", bus.errcnt_o_ienc, 255);
        check("sat_err",  bus.err_o_ienc,    1);
        check("sat_ivld", bus.ivld_o_ienc,   0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_inst_fetch_encoder
`default_nettype wire
